lab4_net_ring_output_arbiter: RTL and testbench
===============================================

// Module: lab4_net_ring_output_arbiter
//
// PURPOSE
//  Per-output-port scheduler for a ring router. Three input queues (prev, term/inject,
//  next) each present a message plus the 2-bit route from the greedy route compute
//  stage. This block grants one eligible input per cycle using round-robin priority.
//  It tracks downstream buffer credits and enforces the bubble rule on injection,
//  which keeps the ring deadlock-free. One instance sits on each router output
//  (PREV, NEXT, TERM).
//
// PARAMETERS
//  p_out_dir      2'b01  route code this output serves (00=PREV, 01=NEXT, 10=TERM)
//  p_msg_nbits    44     message width in bits
//  p_num_credits  4      downstream buffer depth; initial credit count, >=2
//  c_cred_nbits   $clog2(p_num_credits+1)  derived; not set outside the module
//
// PORTS
//  clk         in   1               clock; all state updates on the rising edge
//  reset       in   1               asynchronous, active-low reset
//  in_val      in   3               per-input valid; [0]=prev, [1]=term/inject, [2]=next
//  in_rdy      out  3               per-input ready; at most one bit set (one-hot grant)
//  in_route    in   6               2-bit route per input; input i uses [2i+1:2i]
//  in_msg      in   3*p_msg_nbits   message per input; input i uses slice i
//  out_val     out  1               registered send strobe toward downstream buffer
//  out_msg     out  p_msg_nbits     registered message; valid only when out_val=1
//  credit_ret  in   1               downstream freed one slot (one-cycle pulse)
//  credits     out  c_cred_nbits    current credit count
//  credit_err  out  1               sticky: credit_ret seen while credits==p_num_credits
//
// BEHAVIOUR
//  - Reset (reset==0, async): out_val=0, out_msg=0, credits=p_num_credits,
//    prio_ptr=0, credit_err=0. in_rdy is forced to 0 while reset is asserted.
//  - Eligibility of input i requires both:
//    * in_val[i] && in_route[i]==p_out_dir
//    * a credit gate:
//      > inputs 0 and 2: credits>=1
//      > input 1 when p_out_dir!=TERM: credits>=2 (bubble rule)
//      > input 1 when p_out_dir==TERM: credits>=1
//  - Arbitration is combinational, in the same cycle. Inputs are scanned starting
//    at prio_ptr: order ptr, ptr+1, ptr+2, all mod 3. The first eligible input g
//    gets in_rdy[g]=1. The transfer happens when in_val[g]&&in_rdy[g].
//    in_rdy never depends on out_val or any downstream ready.
//  - Rising edge after a transfer:
//    * out_val<=1, out_msg<=in_msg[g]. Latency is exactly 1 cycle.
//    * prio_ptr<=(g+1) mod 3.
//  - Rising edge with no transfer: out_val<=0, out_msg holds its value, prio_ptr holds.
//  - Credit counter, next value:
//    * send only: credits-1
//    * credit_ret only: credits+1
//    * both in the same cycle: unchanged
//    * Underflow cannot occur; the gate forbids a send at credits==0.
//    * credit_ret at credits==p_num_credits with no send: credits stays saturated,
//      credit_err<=1. credit_err clears only on reset.
//  - Inputs whose route is not p_out_dir are never granted and never stalled here;
//    the other output arbiters serve them.
//  - Throughput: 1 message/cycle while credits are available. Credits do not recover
//    until credit_ret, so sustained rate is set by the downstream drain rate.
//  - Reset mid-operation: the in-flight out_msg is dropped. Downstream must be reset
//    together with this block so the credit count stays consistent.
//
// TESTING
//  1. Single input: in_val=3'b001, route0=p_out_dir, credits=4
//     -> in_rdy=001 that cycle; next cycle out_val=1 with msg0, credits=3.
//  2. Round-robin: all three inputs valid and routed here, credit_ret held 1 each cycle
//     -> grants 0,1,2,0,1,2 on consecutive cycles; credits stay at 4.
//  3. Bubble rule (p_out_dir=NEXT): drain to credits=1, then only input 1 valid
//     -> in_rdy=000. Pulse credit_ret -> credits=2, input 1 granted the next cycle.
//  4. Route filter: all inputs valid, none routed to p_out_dir
//     -> in_rdy=000, out_val stays 0, credits unchanged.
//  5. Simultaneous send and credit_ret at credits=2 -> credits remains 2.
//     credit_ret at credits=4 with no send -> credit_err=1, credits stays 4.
//  6. Assert reset asynchronously mid-stream (between edges)
//     -> out_val=0, credits=4, in_rdy=000 immediately. First grant after release
//     goes to input 0 (prio_ptr=0).

Source files
------------

// File: rtl/lab4_net_ring_output_arbiter.sv
//------------------------------------------------------------------------------
// lab4_net_ring_output_arbiter : per-output round-robin scheduler for a ring
// router with downstream credit tracking and the injection bubble rule.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lab4_net_ring_output_arbiter #(
  parameter logic [1:0] p_out_dir     = 2'b01,
  parameter int         p_msg_nbits   = 44,
  parameter int         p_num_credits = 4,
  localparam int        c_cred_nbits  = $clog2(p_num_credits + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 in_val,
  output logic [2:0]                 in_rdy,
  input  logic [5:0]                 in_route,
  input  logic [3*p_msg_nbits-1:0]   in_msg,
  output logic                       out_val,
  output logic [p_msg_nbits-1:0]     out_msg,
  input  logic                       credit_ret,
  output logic [c_cred_nbits-1:0]    credits,
  output logic                       credit_err
);

  localparam logic [1:0]              c_dir_term  = 2'b10;
  localparam logic [c_cred_nbits-1:0] c_cred_full = c_cred_nbits'(p_num_credits);
  localparam logic [c_cred_nbits-1:0] c_cred_one  = c_cred_nbits'(1);
  localparam logic [c_cred_nbits-1:0] c_cred_two  = c_cred_nbits'(2);

  logic [1:0]              prio_q,    prio_d;
  logic [c_cred_nbits-1:0] credits_q, credits_d;
  logic                    out_val_q, out_val_d;
  logic [p_msg_nbits-1:0]  out_msg_q, out_msg_d;
  logic                    cred_err_q, cred_err_d;

  logic [2:0] w_elig;
  logic [2:0] w_grant;
  logic       w_send;
  logic       w_has1;
  logic       w_has2;

  assign w_has1 = (credits_q != '0);
  assign w_has2 = (credits_q >= c_cred_two);

  // Injection toward another ring hop must leave one free slot (bubble) so
  // ring traffic can always drain; ejection to the terminal needs no bubble.
  for (genvar i = 0; i < 3; i++) begin : g_elig
    logic w_gate;
    if (i == 1) begin : g_inject
      assign w_gate = (p_out_dir == c_dir_term) ? w_has1 : w_has2;
    end else begin : g_ring
      assign w_gate = w_has1;
    end
    assign w_elig[i] = in_val[i] && (in_route[2*i +: 2] == p_out_dir) && w_gate;
  end

  always_comb begin
    w_grant = 3'b000;
    case (prio_q)
      2'd1: begin
        if      (w_elig[1]) w_grant = 3'b010;
        else if (w_elig[2]) w_grant = 3'b100;
        else if (w_elig[0]) w_grant = 3'b001;
      end
      2'd2: begin
        if      (w_elig[2]) w_grant = 3'b100;
        else if (w_elig[0]) w_grant = 3'b001;
        else if (w_elig[1]) w_grant = 3'b010;
      end
      default: begin
        if      (w_elig[0]) w_grant = 3'b001;
        else if (w_elig[1]) w_grant = 3'b010;
        else if (w_elig[2]) w_grant = 3'b100;
      end
    endcase
  end

  // Grants are already qualified by in_val, so any grant is a transfer.
  assign w_send = |w_grant;
  assign in_rdy = reset ? w_grant : 3'b000;

  always_comb begin
    out_val_d = w_send;
    out_msg_d = out_msg_q;
    prio_d    = prio_q;
    case (w_grant)
      3'b001: begin
        out_msg_d = in_msg[0*p_msg_nbits +: p_msg_nbits];
        prio_d    = 2'd1;
      end
      3'b010: begin
        out_msg_d = in_msg[1*p_msg_nbits +: p_msg_nbits];
        prio_d    = 2'd2;
      end
      3'b100: begin
        out_msg_d = in_msg[2*p_msg_nbits +: p_msg_nbits];
        prio_d    = 2'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    credits_d  = credits_q;
    cred_err_d = cred_err_q;
    if (w_send && !credit_ret) begin
      credits_d = credits_q - c_cred_one;
    end else if (!w_send && credit_ret) begin
      if (credits_q == c_cred_full) cred_err_d = 1'b1;
      else                          credits_d  = credits_q + c_cred_one;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q     <= 2'd0;
      credits_q  <= c_cred_full;
      out_val_q  <= 1'b0;
      out_msg_q  <= '0;
      cred_err_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      credits_q  <= credits_d;
      out_val_q  <= out_val_d;
      out_msg_q  <= out_msg_d;
      cred_err_q <= cred_err_d;
    end
  end

  assign out_val    = out_val_q;
  assign out_msg    = out_msg_q;
  assign credits    = credits_q;
  assign credit_err = cred_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lab4_net_ring_output_arbiter.sv
//------------------------------------------------------------------------------
// tb_lab4_net_ring_output_arbiter : directed plus random checks of the ring
// output arbiter against a queue-free behavioural model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lab4_net_ring_output_arbiter;

  localparam logic [1:0] DIR  = 2'b01;
  localparam int         MW   = 44;
  localparam int         NCR  = 4;
  localparam int         CW   = $clog2(NCR + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      in_val;
  logic [2:0]      in_rdy;
  logic [5:0]      in_route;
  logic [3*MW-1:0] in_msg;
  logic            out_val;
  logic [MW-1:0]   out_msg;
  logic            credit_ret;
  logic [CW-1:0]   credits;
  logic            credit_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_ptr;
  int            m_cred;
  bit            m_err;
  bit            m_val;
  logic [MW-1:0] m_msg;

  always #5 clk = ~clk;

  lab4_net_ring_output_arbiter #(
    .p_out_dir    (DIR),
    .p_msg_nbits  (MW),
    .p_num_credits(NCR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_route  (in_route),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_msg   (out_msg),
    .credit_ret(credit_ret),
    .credits   (credits),
    .credit_err(credit_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_elig(int i);
    int need;
    need = (i == 1 && DIR != 2'b10) ? 2 : 1;
    return in_val[i] && (in_route[2*i +: 2] == DIR) && (m_cred >= need);
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (m_elig(i)) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr  = 0;
    m_cred = NCR;
    m_err  = 0;
    m_val  = 0;
    m_msg  = '0;
  endtask

  task automatic rand_msgs();
    logic [63:0] t;
    for (int i = 0; i < 3; i++) begin
      t = {$urandom(), $urandom()};
      in_msg[i*MW +: MW] = t[MW-1:0];
    end
  endtask

  // One clock cycle: apply inputs, check the grant, clock, check the outputs.
  task automatic step(input logic [2:0] v, input logic [5:0] r, input logic ret);
    int          g;
    logic [2:0]  exp_rdy;
    in_val     = v;
    in_route   = r;
    credit_ret = ret;
    rand_msgs();
    #1;
    g       = m_pick();
    exp_rdy = (g < 0) ? 3'b000 : (3'b001 << g);
    chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    if (g >= 0) begin
      m_val = 1;
      m_msg = in_msg[g*MW +: MW];
      m_ptr = (g + 1) % 3;
    end else begin
      m_val = 0;
    end
    if (g >= 0 && !ret)      m_cred--;
    else if (g < 0 && ret) begin
      if (m_cred == NCR) m_err = 1;
      else               m_cred++;
    end
    @(posedge clk);
    #1;
    chk("out_val",    64'(out_val),    64'(m_val));
    chk("out_msg",    64'(out_msg),    64'(m_msg));
    chk("credits",    64'(credits),    64'(m_cred));
    chk("credit_err", 64'(credit_err), 64'(m_err));
  endtask

  initial begin
    reset      = 1'b0;
    in_val     = 3'b000;
    in_route   = 6'b000000;
    in_msg     = '0;
    credit_ret = 1'b0;
    m_reset();
    #12;
    chk("rst_in_rdy",  64'(in_rdy),     64'(3'b000));
    chk("rst_out_val", 64'(out_val),    64'(1'b0));
    chk("rst_out_msg", 64'(out_msg),    64'(0));
    chk("rst_credits", 64'(credits),    64'(NCR));
    chk("rst_err",     64'(credit_err), 64'(1'b0));
    @(negedge clk);
    reset = 1'b1;

    // Single input routed here
    step(3'b001, 6'b00_00_01, 1'b0);
    chk("t1_credits3", 64'(credits), 64'(3));
    step(3'b000, 6'b00_00_00, 1'b1);

    // Round robin with credit returned every cycle
    for (int n = 0; n < 6; n++) step(3'b111, 6'b01_01_01, 1'b1);
    chk("t2_credits4", 64'(credits), 64'(NCR));

    // Bubble rule: drain to one credit, injection must stall
    for (int n = 0; n < 3; n++) step(3'b101, 6'b01_01_01, 1'b0);
    chk("t3_credits1", 64'(credits), 64'(1));
    step(3'b010, 6'b01_01_01, 1'b0);
    step(3'b000, 6'b01_01_01, 1'b1);
    step(3'b010, 6'b01_01_01, 1'b0);
    chk("t3_inject_sent", 64'(out_val), 64'(1'b1));

    // Route filter
    step(3'b000, 6'b00_00_00, 1'b1);
    step(3'b111, 6'b10_00_10, 1'b0);
    step(3'b111, 6'b00_10_00, 1'b0);
    chk("t4_no_send", 64'(out_val), 64'(1'b0));

    // Send and return together, then an overflowing return
    step(3'b001, 6'b00_00_01, 1'b1);
    chk("t5_credits2", 64'(credits), 64'(2));
    step(3'b000, 6'b00_00_00, 1'b1);
    step(3'b000, 6'b00_00_00, 1'b1);
    step(3'b000, 6'b00_00_00, 1'b1);
    chk("t5_err", 64'(credit_err), 64'(1'b1));
    chk("t5_sat", 64'(credits),    64'(NCR));

    // Random traffic with legal credit returns
    for (int n = 0; n < 400; n++) begin
      logic [2:0] v;
      logic [5:0] r;
      logic       ret;
      v   = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++)
        r[2*i +: 2] = ($urandom_range(0, 2) != 0) ? DIR : 2'($urandom_range(0, 3));
      ret = ($urandom_range(0, 2) != 0) && (m_cred < NCR);
      step(v, r, ret);
    end

    // Asynchronous reset between edges
    in_val   = 3'b111;
    in_route = 6'b01_01_01;
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    chk("arst_in_rdy",  64'(in_rdy),     64'(3'b000));
    chk("arst_out_val", 64'(out_val),    64'(1'b0));
    chk("arst_credits", 64'(credits),    64'(NCR));
    chk("arst_err",     64'(credit_err), 64'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    step(3'b111, 6'b01_01_01, 1'b0);
    chk("arst_first_msg", 64'(out_msg), 64'(in_msg[0 +: MW]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
